// File: rtl/unidade_controle_genius_param_if.sv
// Control/status bundle between the Genius control unit and the datapath/top level.
// The master side is the control unit; the slave side is the datapath and game top.
interface unidade_controle_genius_param_if #(
  parameter int LIVES = 1
);
  localparam int VW = $clog2(LIVES + 1);

  logic          iniciar;
  logic          jogada;
  logic          igual;
  logic          enderecoIgualSequencia;
  logic          fimS;
  logic          modo;
  logic          zeraR;
  logic          zeraE;
  logic          zeraS;
  logic          zeraM;
  logic          registraR;
  logic          registraM;
  logic          contaE;
  logic          contaS;
  logic          acertou;
  logic          errou;
  logic          pronto;
  logic          perdeu_timeout;
  logic [VW-1:0] vidas;
  logic [4:0]    db_estado;

  modport master (
    input  iniciar, jogada, igual, enderecoIgualSequencia, fimS, modo,
    output zeraR, zeraE, zeraS, zeraM, registraR, registraM, contaE, contaS,
    output acertou, errou, pronto, perdeu_timeout, vidas, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, enderecoIgualSequencia, fimS, modo,
    input  zeraR, zeraE, zeraS, zeraM, registraR, registraM, contaE, contaS,
    input  acertou, errou, pronto, perdeu_timeout, vidas, db_estado
  );
endinterface

// File: rtl/unidade_controle_genius_param.sv
// Genius control unit: show / play / compare loop with lives, round replay,
// blind mode, LED display timer and per-play timeout.
module unidade_controle_genius_param #(
  parameter int LED_ON_CYCLES  = 4,
  parameter int LED_OFF_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 10,
  parameter int LIVES          = 1
) (
  input logic clock,
  input logic reset,
  unidade_controle_genius_param_if.master bus
);
  localparam int VW       = $clog2(LIVES + 1);
  localparam int TMR_SPAN = (LED_ON_CYCLES > LED_OFF_CYCLES) ? LED_ON_CYCLES : LED_OFF_CYCLES;
  localparam int TW       = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;
  localparam int OW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [4:0] {
    S_INICIAL        = 5'd0,
    S_INICIA_SEQ     = 5'd1,
    S_PROX_SEQ       = 5'd2,
    S_ULTIMA_SEQ     = 5'd3,
    S_CARREGA        = 5'd4,
    S_MOSTRA         = 5'd5,
    S_APAGA          = 5'd6,
    S_MOSTRA_APAGADO = 5'd7,
    S_PROX_POS       = 5'd8,
    S_COMECO_JOGADA  = 5'd9,
    S_ESPERA         = 5'd10,
    S_REGISTRA       = 5'd11,
    S_COMPARA        = 5'd12,
    S_PROX_JOGADA    = 5'd13,
    S_PERDE_VIDA     = 5'd14,
    S_ACERTO         = 5'd15,
    S_ERRO           = 5'd16
  } state_t;

  state_t        state_reg, state_next;
  logic [VW-1:0] vidas_reg, vidas_next;
  logic          modo_reg, modo_next;
  logic          tout_flag_reg, tout_flag_next;
  logic [TW-1:0] tmr_reg;
  logic [OW-1:0] tout_reg;
  logic [7:0]    ctrl_reg;   // {zeraR, zeraE, zeraS, zeraM, registraR, registraM, contaE, contaS}
  logic [3:0]    flag_reg;   // {acertou, errou, pronto, perdeu_timeout}
  logic          err;

  function automatic logic [7:0] ctrl_of(state_t s);
    case (s)
      S_INICIAL:       ctrl_of = 8'b1011_0000;
      S_INICIA_SEQ:    ctrl_of = 8'b0110_0000;
      S_PROX_SEQ:      ctrl_of = 8'b0100_0001;
      S_CARREGA:       ctrl_of = 8'b0000_0100;
      S_APAGA:         ctrl_of = 8'b0001_0000;
      S_PROX_POS:      ctrl_of = 8'b0000_0010;
      S_COMECO_JOGADA: ctrl_of = 8'b0100_0000;
      S_REGISTRA:      ctrl_of = 8'b0000_1000;
      S_PROX_JOGADA:   ctrl_of = 8'b0000_0010;
      S_PERDE_VIDA:    ctrl_of = 8'b1100_0000;
      default:         ctrl_of = 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] flags_of(state_t s, logic tout_flag);
    flags_of = {s == S_ACERTO, s == S_ERRO, (s == S_ACERTO) || (s == S_ERRO),
                (s == S_ERRO) && tout_flag};
  endfunction

  always_comb begin
    state_next     = state_reg;
    vidas_next     = vidas_reg;
    modo_next      = modo_reg;
    tout_flag_next = tout_flag_reg;
    err            = 1'b0;
    case (state_reg)
      S_INICIAL: begin
        tout_flag_next = 1'b0;
        if (bus.iniciar) begin
          state_next = S_INICIA_SEQ;
          modo_next  = bus.modo;
          vidas_next = VW'(LIVES);
        end
      end
      S_INICIA_SEQ, S_PROX_SEQ, S_PERDE_VIDA:
        state_next = modo_reg ? S_COMECO_JOGADA : S_CARREGA;
      S_CARREGA: state_next = S_MOSTRA;
      S_MOSTRA:
        if (tmr_reg == TW'(LED_ON_CYCLES - 1)) state_next = S_APAGA;
      S_APAGA: state_next = S_MOSTRA_APAGADO;
      S_MOSTRA_APAGADO:
        if (tmr_reg == TW'(LED_OFF_CYCLES - 1))
          state_next = bus.enderecoIgualSequencia ? S_COMECO_JOGADA : S_PROX_POS;
      S_PROX_POS:      state_next = S_CARREGA;
      S_COMECO_JOGADA: state_next = S_ESPERA;
      S_ESPERA: begin
        // A play arriving on the last allowed cycle still counts.
        if (bus.jogada) begin
          state_next = S_REGISTRA;
        end else if (tout_reg == OW'(TIMEOUT_CYCLES - 1)) begin
          err            = 1'b1;
          tout_flag_next = 1'b1;
        end
      end
      S_REGISTRA: state_next = S_COMPARA;
      S_COMPARA: begin
        if (bus.igual) begin
          state_next = bus.enderecoIgualSequencia ? S_ULTIMA_SEQ : S_PROX_JOGADA;
        end else begin
          err            = 1'b1;
          tout_flag_next = 1'b0;
        end
      end
      S_PROX_JOGADA: state_next = S_ESPERA;
      S_ULTIMA_SEQ:  state_next = bus.fimS ? S_ACERTO : S_PROX_SEQ;
      S_ACERTO, S_ERRO:
        if (bus.iniciar) state_next = S_INICIAL;
      default: state_next = S_INICIAL;
    endcase

    if (err) begin
      if (vidas_reg > VW'(1)) begin
        state_next = S_PERDE_VIDA;
        vidas_next = vidas_reg - VW'(1);
      end else begin
        state_next = S_ERRO;
        vidas_next = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= S_INICIAL;
      vidas_reg     <= VW'(LIVES);
      modo_reg      <= 1'b0;
      tout_flag_reg <= 1'b0;
      tmr_reg       <= '0;
      tout_reg      <= '0;
      ctrl_reg      <= ctrl_of(S_INICIAL);
      flag_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      vidas_reg     <= vidas_next;
      modo_reg      <= modo_next;
      tout_flag_reg <= tout_flag_next;
      ctrl_reg      <= ctrl_of(state_next);
      flag_reg      <= flags_of(state_next, tout_flag_next);

      case (state_reg)
        S_CARREGA, S_APAGA: tmr_reg <= '0;
        S_MOSTRA, S_MOSTRA_APAGADO:
          if (tmr_reg != {TW{1'b1}}) tmr_reg <= tmr_reg + TW'(1);
        default: tmr_reg <= tmr_reg;
      endcase

      case (state_reg)
        S_COMECO_JOGADA, S_PROX_JOGADA: tout_reg <= '0;
        S_ESPERA:
          if (tout_reg != {OW{1'b1}}) tout_reg <= tout_reg + OW'(1);
        default: tout_reg <= tout_reg;
      endcase
    end
  end

  assign bus.zeraR          = ctrl_reg[7];
  assign bus.zeraE          = ctrl_reg[6];
  assign bus.zeraS          = ctrl_reg[5];
  assign bus.zeraM          = ctrl_reg[4];
  assign bus.registraR      = ctrl_reg[3];
  assign bus.registraM      = ctrl_reg[2];
  assign bus.contaE         = ctrl_reg[1];
  assign bus.contaS         = ctrl_reg[0];
  assign bus.acertou        = flag_reg[3];
  assign bus.errou          = flag_reg[2];
  assign bus.pronto         = flag_reg[1];
  assign bus.perdeu_timeout = flag_reg[0];
  assign bus.vidas          = vidas_reg;
  assign bus.db_estado      = state_reg;
endmodule

// File: tb/tb_unidade_controle_genius_param.sv
// Scoreboard bench: a 2-step game datapath model feeds the control unit; expected
// outcome events are queued per game and a monitor checks them as they appear.
module tb_unidade_controle_genius_param;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  unidade_controle_genius_param_if #(.LIVES(2)) bus ();

  unidade_controle_genius_param #(
    .LED_ON_CYCLES (4),
    .LED_OFF_CYCLES(2),
    .TIMEOUT_CYCLES(10),
    .LIVES         (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Datapath model: E/S counters of a 2-step game.
  int e_cnt = 0;
  int s_cnt = 0;
  always @(posedge clock) begin
    if (bus.zeraE) e_cnt <= 0; else if (bus.contaE) e_cnt <= e_cnt + 1;
    if (bus.zeraS) s_cnt <= 0; else if (bus.contaS) s_cnt <= s_cnt + 1;
  end
  assign bus.enderecoIgualSequencia = (e_cnt == s_cnt);
  assign bus.fimS                   = (s_cnt == 1);

  typedef struct {
    int delay;   // ESPERA cycle (1-based) with jogada high; 0 = never
    int ok;
  } play_t;

  typedef struct {
    string name;
    int st, vidas, ctrl, ac, er, pr, pt, regm, contas, zeram, esp;
  } exp_t;

  play_t plays[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push(input string name, input int st, input int vidas, input int ctrl,
                      input int ac, input int er, input int pr, input int pt,
                      input int regm, input int contas, input int zeram, input int esp);
    exp_t x;
    x = '{name, st, vidas, ctrl, ac, er, pr, pt, regm, contas, zeram, esp};
    exp_q.push_back(x);
  endtask

  task automatic add_play(input int delay, input int ok);
    play_t p;
    p = '{delay, ok};
    plays.push_back(p);
  endtask

  task automatic chk(input string name, input string field, input int act, input int expv);
    if (expv >= 0) begin
      checks++;
      if (act != expv) begin
        errors++;
        $display("FAIL %s.%s: got %0d expected %0d", name, field, act, expv);
      end
    end
  endtask

  // Play driver: one play consumed per ESPERA visit.
  initial begin
    int    c, dprev, cnt;
    play_t p;
    bus.jogada = 1'b0;
    bus.igual  = 1'b0;
    dprev = -1;
    cnt   = 0;
    p     = '{0, 1};
    forever begin
      @(negedge clock);
      c = int'(bus.db_estado);
      if (c == 10) begin
        if (dprev != 10) begin
          if (plays.size() > 0) p = plays.pop_front(); else p = '{0, 1};
          cnt = 1;
        end else begin
          cnt++;
        end
      end
      bus.jogada = (c == 10) && (p.delay == cnt);
      bus.igual  = (p.ok != 0);
      dprev = c;
    end
  end

  logic rst_s = 1'b1;
  initial forever begin
    @(posedge clock);
    rst_s = reset;
  end

  // Monitor: accumulates pulse counts between events and checks each event.
  initial begin
    int   cur, prev, regm, contas, zeram, esp_cur, esp_last, m_cur, m_bad;
    logic rst_ev;
    exp_t x;
    prev = -1; regm = 0; contas = 0; zeram = 0;
    esp_cur = 0; esp_last = 0; m_cur = 0; m_bad = 0;
    forever begin
      @(negedge clock);
      cur = int'(bus.db_estado);
      if (bus.registraM) regm++;
      if (bus.contaS) contas++;
      if (bus.zeraM) zeram++;
      if (cur == 10) esp_cur = (prev == 10) ? esp_cur + 1 : 1;
      else if (prev == 10) esp_last = esp_cur;
      if (cur == 5) m_cur = (prev == 5) ? m_cur + 1 : 1;
      else if (prev == 5 && m_cur != 4) m_bad = 1;
      if (cur == 1 && prev == 0) begin
        regm = 0; contas = 0; zeram = 0; m_bad = 0;
      end
      rst_ev = !rst_s;
      if (rst_ev || (cur != prev && (cur == 14 || cur == 15 || cur == 16))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got state %0d expected no event", cur);
        end else begin
          x = exp_q.pop_front();
          chk(x.name, "state", cur, x.st);
          chk(x.name, "vidas", int'(bus.vidas), x.vidas);
          chk(x.name, "ctrl", int'({bus.zeraR, bus.zeraE, bus.zeraS, bus.zeraM,
                                     bus.registraR, bus.registraM, bus.contaE, bus.contaS}), x.ctrl);
          chk(x.name, "acertou", int'(bus.acertou), x.ac);
          chk(x.name, "errou", int'(bus.errou), x.er);
          chk(x.name, "pronto", int'(bus.pronto), x.pr);
          chk(x.name, "perdeu_timeout", int'(bus.perdeu_timeout), x.pt);
          chk(x.name, "registraM_pulses", regm, x.regm);
          chk(x.name, "contaS_pulses", contas, x.contas);
          chk(x.name, "zeraM_pulses", zeram, x.zeram);
          chk(x.name, "espera_cycles", esp_last, x.esp);
          if (!rst_ev) chk(x.name, "mostra_len_bad", m_bad, 0);
          $display("event %s: state=%0d vidas=%0d regM=%0d contaS=%0d espera=%0d",
                   x.name, cur, bus.vidas, regm, contas, esp_last);
        end
        regm = 0; contas = 0; zeram = 0; m_bad = 0;
      end
      prev = cur;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_drain: got %0d pending events expected 0 after %0d cycles",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(bus.db_estado) != s && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (int'(bus.db_estado) != s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: got state %0d expected %0d", bus.db_estado, s);
    end
  endtask

  task automatic pulse_iniciar();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  task automatic start_game(input logic m);
    @(negedge clock);
    bus.modo = m;
    if (bus.db_estado != 5'd0) pulse_iniciar();
    pulse_iniciar();
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.modo    = 1'b0;
    push("reset", 0, 2, 'hB0, 0, 0, 0, 0, -1, -1, -1, -1);
    @(negedge clock);
    reset = 1'b1;
    wait_drain(20);

    // All plays correct.
    add_play(1, 1); add_play(3, 1); add_play(2, 1);
    push("g1_acerto", 15, 2, 0, 1, 0, 1, 0, 3, 1, 3, 2);
    start_game(1'b0);
    wait_drain(400);

    // One wrong play in round 2, round replayed.
    add_play(2, 1); add_play(2, 0); add_play(2, 1); add_play(2, 1);
    push("g2_perde", 14, 1, 'hC0, 0, 0, 0, 0, 3, 1, 3, 2);
    push("g2_acerto", 15, 1, 0, 1, 0, 1, 0, 2, 0, 2, 2);
    start_game(1'b0);
    wait_drain(600);

    // Two consecutive wrong plays.
    add_play(2, 0); add_play(2, 0);
    push("g3_perde", 14, 1, 'hC0, 0, 0, 0, 0, 1, 0, 1, 2);
    push("g3_erro", 16, 0, 0, 0, 1, 1, 0, 1, 0, 1, 2);
    start_game(1'b0);
    wait_drain(400);

    // Timeout, then a play on the last allowed cycle, then a final timeout.
    add_play(0, 1); add_play(10, 1); add_play(0, 1);
    push("g4_perde_tout", 14, 1, 'hC0, 0, 0, 0, 0, 1, 0, 1, 10);
    push("g4_erro_tout", 16, 0, 0, 0, 1, 1, 1, 3, 1, 3, 10);
    start_game(1'b0);
    wait_drain(600);

    // Blind mode; modo dropped mid-game must not matter.
    add_play(2, 1); add_play(2, 1); add_play(2, 1);
    push("g5_blind", 15, 2, 0, 1, 0, 1, 0, 0, 1, 0, 2);
    start_game(1'b1);
    wait_state(10, 100);
    bus.modo = 1'b0;
    wait_drain(400);

    // Lose a life, reset during the replay display, then a fresh game.
    add_play(2, 0);
    push("g6_perde", 14, 1, 'hC0, 0, 0, 0, 0, 1, 0, 1, 2);
    start_game(1'b0);
    wait_drain(400);
    wait_state(5, 50);
    plays.delete();
    push("g6_reset", 0, 2, 'hB0, 0, 0, 0, 0, -1, -1, -1, -1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wait_drain(20);
    add_play(2, 1); add_play(2, 1); add_play(2, 1);
    push("g6_fresh", 15, 2, 0, 1, 0, 1, 0, 3, 1, 3, 2);
    start_game(1'b0);
    wait_drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
